// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mux_rr_arbiter
// Brief   : Round-robin arbiter that drives the select key of an NR_REQ:1 data
//           mux and registers the chosen word under a valid/ready handshake.
//           Optional build macro MUX_ARB_LOCK_EN adds a `lock` input that pins
//           the grant to the current requester across accepts.
// Revision: 1.0 - initial release
// ============================================================================
module mux_rr_arbiter #(
  parameter int NR_REQ   = 4,
  parameter int SEL_LEN  = 2,
  parameter int DATA_LEN = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NR_REQ-1:0]            req,
  input  logic [NR_REQ*DATA_LEN-1:0]   in_data,
  output logic [NR_REQ-1:0]            ack,
  output logic                         out_valid,
  input  logic                         out_ready,
`ifdef MUX_ARB_LOCK_EN
  input  logic                         lock,
`endif
  output logic [DATA_LEN-1:0]          out_data,
  output logic [SEL_LEN-1:0]           sel,
  output logic [NR_REQ-1:0]            gnt
);

  generate
    if ((NR_REQ < 2) || (NR_REQ > 16) || ((2 ** SEL_LEN) < NR_REQ)) begin : g_bad_params
      $error("mux_rr_arbiter: NR_REQ must be 2..16 and 2**SEL_LEN >= NR_REQ");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [SEL_LEN-1:0]    r_ptr;
  logic [SEL_LEN-1:0]    r_sel;
  logic [NR_REQ-1:0]     r_gnt;
  logic [DATA_LEN-1:0]   r_data;

  logic                  w_accept;
  logic                  w_lock;
  logic [SEL_LEN-1:0]    w_ptr_adv;
  logic [SEL_LEN-1:0]    w_ptr_next;
  logic [NR_REQ-1:0]     w_arb_vec;
  logic                  w_hi_found;
  logic                  w_lo_found;
  logic [SEL_LEN-1:0]    w_hi_idx;
  logic [SEL_LEN-1:0]    w_lo_idx;
  logic                  w_found;
  logic [SEL_LEN-1:0]    w_win;
  logic                  w_load;
  logic [SEL_LEN-1:0]    w_load_idx;
  logic [NR_REQ-1:0]     w_onehot;

`ifdef MUX_ARB_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif

  assign w_accept   = (r_state == ST_BUSY) && out_ready;
  assign w_ptr_adv  = (r_sel == SEL_LEN'(NR_REQ - 1)) ? '0 : r_sel + 1'b1;
  assign w_ptr_next = (w_accept && !w_lock) ? w_ptr_adv : r_ptr;
  // The word being accepted is excluded so a still-high req waits one cycle.
  assign w_arb_vec  = (r_state == ST_BUSY) ? (req & ~r_gnt) : req;

  // Lowest set index at or above the pointer wins, else lowest below it.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = NR_REQ - 1; i >= 0; i--) begin
      if (w_arb_vec[i]) begin
        if (i >= int'(w_ptr_next)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = SEL_LEN'(i);
        end else begin
          w_lo_found = 1'b1;
          w_lo_idx   = SEL_LEN'(i);
        end
      end
    end
  end

  assign w_found = w_hi_found | w_lo_found;
  assign w_win   = w_hi_found ? w_hi_idx : w_lo_idx;

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_idx   = w_win;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_load       = 1'b1;
          w_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_accept) begin
          if (w_lock) begin
            w_load_idx = r_sel;
            if (req[r_sel]) w_load = 1'b1;
            else            w_state_next = ST_IDLE;
          end else if (w_found) begin
            w_load = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_onehot = {{(NR_REQ-1){1'b0}}, 1'b1} << w_load_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_gnt   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      if (w_load) begin
        r_sel  <= w_load_idx;
        r_gnt  <= w_onehot;
        r_data <= in_data[int'(w_load_idx)*DATA_LEN +: DATA_LEN];
      end else if (w_state_next == ST_IDLE) begin
        r_gnt  <= '0;
      end
    end
  end

  assign out_valid = (r_state == ST_BUSY);
  assign sel       = r_sel;
  assign gnt       = r_gnt;
  assign out_data  = r_data;
  assign ack       = r_gnt & {NR_REQ{out_valid & out_ready}};

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mux_rr_arbiter
// Brief   : Self-checking bench for mux_rr_arbiter: directed scenarios plus
//           randomized traffic against a transaction-level round-robin model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter;
  localparam int NR_REQ   = 4;
  localparam int SEL_LEN  = 2;
  localparam int DATA_LEN = 8;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic [NR_REQ-1:0]           req;
  logic [NR_REQ*DATA_LEN-1:0]  in_data;
  logic [NR_REQ-1:0]           ack;
  logic                        out_valid;
  logic                        out_ready;
  logic                        lock;
  logic [DATA_LEN-1:0]         out_data;
  logic [SEL_LEN-1:0]          sel;
  logic [NR_REQ-1:0]           gnt;

  int n_checks = 0;
  int n_fail   = 0;

  // {out_valid, sel, gnt, out_data, ack}
  logic [18:0] obs;
  assign obs = {out_valid, sel, gnt, out_data, ack};

  mux_rr_arbiter #(
    .NR_REQ   (NR_REQ),
    .SEL_LEN  (SEL_LEN),
    .DATA_LEN (DATA_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_data   (in_data),
    .ack       (ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef MUX_ARB_LOCK_EN
    .lock      (lock),
`endif
    .out_data  (out_data),
    .sel       (sel),
    .gnt       (gnt)
  );

  always #5 clk = ~clk;

  // Reference model: transfer-level view of the arbiter.
  int               m_ptr;
  int               m_sel;
  bit               m_valid;
  logic [7:0]       m_data;
  int               mw;
  int               mp;
  logic [3:0]       mv;
  logic             m_lock;

`ifdef MUX_ARB_LOCK_EN
  assign m_lock = lock;
`else
  assign m_lock = 1'b0;
`endif

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < NR_REQ; k++)
      if (v[(p + k) % NR_REQ]) return (p + k) % NR_REQ;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_sel <= 0; m_data <= 8'h00; m_ptr <= 0;
    end else if (!m_valid) begin
      mw = rr_pick(req, m_ptr);
      if (mw >= 0) begin
        m_valid <= 1'b1; m_sel <= mw; m_data <= in_data[8*mw +: 8];
      end
    end else if (out_ready) begin
      if (m_lock) begin
        if (req[m_sel]) m_data <= in_data[8*m_sel +: 8];
        else            m_valid <= 1'b0;
      end else begin
        mp = (m_sel + 1) % NR_REQ;
        m_ptr <= mp;
        mv = req;
        mv[m_sel] = 1'b0;
        mw = rr_pick(mv, mp);
        if (mw >= 0) begin
          m_sel <= mw; m_data <= in_data[8*mw +: 8];
        end else begin
          m_valid <= 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; out_ready = 1'b0; lock = 1'b0;
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 4'hF; out_ready = 1'b1; lock = 1'b0;
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (obs !== 19'h0) begin
      n_fail++;
      $display("FAIL reset: got %h expected %h", obs, 19'h0);
    end
    rst_n = 1'b1; req = '0; out_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [18:0] exp;
    do_reset();
    req = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      exp = {1'b1, 2'(k % 4), 4'(1 << (k % 4)), 8'(8'hA0 + k % 4), 4'(1 << (k % 4))};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL round_robin step%0d: got %h expected %h", k, obs, exp);
      end
    end
    req = '0; out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [18:0] exp;
    do_reset();
    req = 4'b0100; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      exp = {1'b1, 2'd2, 4'b0100, 8'hA2, 4'b0000};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL backpressure hold%0d: got %h expected %h", k, obs, exp);
      end
      req = 4'b0001 << (k % 4);
    end
    req = 4'b0100; out_ready = 1'b1; #1;
    exp = {1'b1, 2'd2, 4'b0100, 8'hA2, 4'b0100};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL backpressure accept: got %h expected %h", obs, exp);
    end
    req = '0;
    @(negedge clk); #1;
    n_checks++;
    if ({out_valid, ack} !== 5'b0) begin
      n_fail++;
      $display("FAIL backpressure idle: got %b expected %b", {out_valid, ack}, 5'b0);
    end
  endtask

  // Relies on the pointer being 3 after test_backpressure.
  task automatic test_wrap();
    logic [18:0] exp;
    req = 4'b1001; out_ready = 1'b1;
    @(negedge clk); #1;
    exp = {1'b1, 2'd3, 4'b1000, 8'hA3, 4'b1000};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL wrap_a first: got %h expected %h", obs, exp);
    end
    @(negedge clk); #1;
    exp = {1'b1, 2'd0, 4'b0001, 8'hA0, 4'b0001};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL wrap_a second: got %h expected %h", obs, exp);
    end
    req = '0;
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    req = 4'b0011;
    @(negedge clk); #1;
    exp = {1'b1, 2'd0, 4'b0001, 8'hA0, 4'b0001};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL wrap_b first: got %h expected %h", obs, exp);
    end
    @(negedge clk); #1;
    exp = {1'b1, 2'd1, 4'b0010, 8'hA1, 4'b0010};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL wrap_b second: got %h expected %h", obs, exp);
    end
    req = '0; out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    logic [18:0] exp;
    do_reset();
    req = 4'b0010; out_ready = 1'b0;
    @(negedge clk); #1;
    exp = {1'b1, 2'd1, 4'b0010, 8'hA1, 4'b0000};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL midreset busy: got %h expected %h", obs, exp);
    end
    rst_n = 1'b0; out_ready = 1'b1; #1;
    n_checks++;
    if (obs !== 19'h0) begin
      n_fail++;
      $display("FAIL midreset clear: got %h expected %h", obs, 19'h0);
    end
    @(negedge clk);
    rst_n = 1'b1; req = 4'b1111; out_ready = 1'b0;
    @(negedge clk); #1;
    exp = {1'b1, 2'd0, 4'b0001, 8'hA0, 4'b0000};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL midreset regrant: got %h expected %h", obs, exp);
    end
    req = '0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

`ifdef MUX_ARB_LOCK_EN
  task automatic test_lock();
    logic [18:0] exp;
    do_reset();
    req = 4'b0011; lock = 1'b1; out_ready = 1'b1;
    in_data[7:0] = 8'hB0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      exp = {1'b1, 2'd0, 4'b0001, 8'(8'hB0 + k), 4'b0001};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL lock hold%0d: got %h expected %h", k, obs, exp);
      end
      in_data[7:0] = 8'(8'hB1 + k);
    end
    lock = 1'b0;
    @(negedge clk); #1;
    exp = {1'b1, 2'd1, 4'b0010, 8'hA1, 4'b0010};
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL lock release: got %h expected %h", obs, exp);
    end
    req = '0; out_ready = 1'b0;
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  endtask
`endif

  task automatic test_random();
    logic [18:0] exp;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      rst_n     = ($urandom_range(0, 39) != 0);
      req       = 4'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      lock      = ($urandom_range(0, 3) == 0);
      in_data   = 32'($urandom);
      #1;
      n_checks++;
      if (m_valid) begin
        exp = {1'b1, 2'(m_sel), 4'(1 << m_sel), m_data, out_ready ? 4'(1 << m_sel) : 4'b0};
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL random cycle%0d: got %h expected %h", k, obs, exp);
        end
      end else if ({out_valid, ack} !== 5'b0) begin
        n_fail++;
        $display("FAIL random idle cycle%0d: got %b expected %b", k, {out_valid, ack}, 5'b0);
      end
    end
    rst_n = 1'b1; req = '0; out_ready = 1'b0; lock = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; out_ready = 1'b0; lock = 1'b0; in_data = '0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_reset_mid_busy();
`ifdef MUX_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
